// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: state encoding and frame layout.
package loader_pkg;

   localparam int FRAME_BYTES_PER_WORD = 2;

   typedef enum logic [2:0] {
      ST_LEN_HI  = 3'd0,
      ST_LEN_LO  = 3'd1,
      ST_DATA_HI = 3'd2,
      ST_DATA_LO = 3'd3,
      ST_CSUM    = 3'd4,
      ST_DONE    = 3'd5,
      ST_ERR     = 3'd6
   } state_t;

endpackage

// File: rtl/loader_csum.sv
// Running 8-bit XOR checksum over accepted frame bytes; registered result.
module loader_csum (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic [7:0] din,
   output logic [7:0] csum
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         csum <= 8'h00;
      else if (en)
         csum <= csum ^ din;
   end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses a length/data/checksum byte frame, writes 16-bit words to
// program memory from address 0 and releases the CPU reset only on a good checksum.
module prog_loader
   import loader_pkg::*;
#(
   parameter int AWIDTH = 10,
   parameter int DWIDTH = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              reload,
   output logic              mem_wr,
   output logic [AWIDTH-1:0] mem_addr,
   output logic [DWIDTH-1:0] mem_data,
   output logic              cpu_rst,
   output logic              done,
   output logic              error
);

   localparam logic [16:0] MAX_WORDS = 17'(1) << AWIDTH;

   state_t            state;
   logic [7:0]        len_hi_q;
   logic [7:0]        hi_q;
   logic [AWIDTH:0]   words_left;
   logic              cpu_rst_q;
   logic [7:0]        csum;
   logic              xfer;
   logic              reload_ok;
   logic [15:0]       len_w;

   // Stall one cycle after each write so the memory port never sees back-to-back strobes.
   assign in_ready  = (state <= ST_CSUM) && !mem_wr;
   assign xfer      = in_valid && in_ready;
   assign reload_ok = reload && (state == ST_DONE || state == ST_ERR);
   assign len_w     = {len_hi_q, in_data};
   assign cpu_rst   = cpu_rst_q || reload_ok;

   loader_csum u_csum (
      .clk  (clk),
      .rst  (rst),
      .clr  (reload_ok),
      .en   (xfer && state != ST_CSUM),
      .din  (in_data),
      .csum (csum)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_LEN_HI;
         len_hi_q   <= 8'h00;
         hi_q       <= 8'h00;
         words_left <= '0;
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         mem_data   <= '0;
         cpu_rst_q  <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         mem_wr <= 1'b0;
         if (mem_wr)
            mem_addr <= mem_addr + AWIDTH'(1);
         case (state)
            ST_LEN_HI: if (xfer) begin
               len_hi_q <= in_data;
               state    <= ST_LEN_LO;
            end
            ST_LEN_LO: if (xfer) begin
               if ({1'b0, len_w} > MAX_WORDS) begin
                  state <= ST_ERR;
                  error <= 1'b1;
               end else if (len_w == 16'h0000) begin
                  state <= ST_CSUM;
               end else begin
                  words_left <= (AWIDTH+1)'(len_w);
                  state      <= ST_DATA_HI;
               end
            end
            ST_DATA_HI: if (xfer) begin
               hi_q  <= in_data;
               state <= ST_DATA_LO;
            end
            ST_DATA_LO: if (xfer) begin
               mem_data   <= DWIDTH'({hi_q, in_data});
               mem_wr     <= 1'b1;
               words_left <= words_left - (AWIDTH+1)'(1);
               state      <= (words_left == (AWIDTH+1)'(1)) ? ST_CSUM : ST_DATA_HI;
            end
            ST_CSUM: if (xfer) begin
               if (in_data == csum) begin
                  state     <= ST_DONE;
                  done      <= 1'b1;
                  cpu_rst_q <= 1'b0;
               end else begin
                  state <= ST_ERR;
                  error <= 1'b1;
               end
            end
            ST_DONE, ST_ERR: if (reload) begin
               state     <= ST_LEN_HI;
               done      <= 1'b0;
               error     <= 1'b0;
               cpu_rst_q <= 1'b1;
               mem_addr  <= '0;
            end
            default: state <= ST_LEN_HI;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed plus randomized frames against a queue-based model of the expected writes and outcome.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        rst, in_valid, reload;
   logic [7:0]  in_data;
   logic        in_ready, mem_wr, cpu_rst, done, error;
   logic [9:0]  mem_addr;
   logic [15:0] mem_data;

   prog_loader #(.AWIDTH(10), .DWIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .reload(reload), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
      .cpu_rst(cpu_rst), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   int          checks = 0, errors = 0;
   int          rst_viol = 0;
   int          exp_writes = 0;
   logic [7:0]  frame[$];
   logic [15:0] words[$];
   logic [9:0]  got_a[$];
   logic [15:0] got_d[$];

   always @(negedge clk) begin
      if (mem_wr) begin
         got_a.push_back(mem_addr);
         got_d.push_back(mem_data);
      end
      // CPU may only run once the whole program is written and the load is done
      if (!cpu_rst && (!done || got_a.size() != exp_writes)) rst_viol++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic rand_words(input int n);
      words.delete();
      for (int i = 0; i < n; i++) words.push_back(16'($urandom));
   endtask

   task automatic build(input bit bad);
      logic [7:0] cs;
      int n;
      n = words.size();
      frame.delete();
      frame.push_back(8'(n >> 8));
      frame.push_back(8'(n));
      foreach (words[i]) begin
         frame.push_back(words[i][15:8]);
         frame.push_back(words[i][7:0]);
      end
      cs = 8'h00;
      foreach (frame[i]) cs ^= frame[i];
      if (bad) cs ^= 8'(1 << $urandom_range(7, 0));
      frame.push_back(cs);
      exp_writes = n;
   endtask

   // gap: 0 = always valid, 1 = valid toggles each cycle, 2 = random gaps
   task automatic send(input int nbytes, input int gap);
      int  k = 0, t = 0;
      bit  prev_lo = 1'b0;
      while (k < nbytes && t < 20000) begin
         @(negedge clk);
         t++;
         if (prev_lo) begin chk("wr_latency", 32'(mem_wr), 1); prev_lo = 1'b0; end
         if ((gap == 1 && t % 2 == 0) || (gap == 2 && $urandom_range(0, 99) < 30)) begin
            in_valid = 1'b0;
         end else begin
            in_valid = 1'b1;
            in_data  = frame[k];
            if (in_ready) begin
               prev_lo = (k >= 3) && (k % 2 == 1) && (k < frame.size() - 1);
               k++;
            end
         end
      end
      @(negedge clk);
      in_valid = 1'b0;
      if (prev_lo) chk("wr_latency", 32'(mem_wr), 1);
      if (k < nbytes) chk("send_timeout", 32'(k), 32'(nbytes));
   endtask

   task automatic finish_check(input string tag, input bit exp_ok);
      int t = 0;
      while (!(done || error) && t < 100) begin @(negedge clk); t++; end
      chk({tag, "_done"},    32'(done),     32'(exp_ok));
      chk({tag, "_error"},   32'(error),    32'(!exp_ok));
      chk({tag, "_cpu_rst"}, 32'(cpu_rst),  32'(!exp_ok));
      chk({tag, "_ready"},   32'(in_ready), 0);
      chk({tag, "_nwr"},     32'(got_a.size()), 32'(exp_writes));
      chk({tag, "_addr_end"}, 32'(mem_addr), 32'(exp_writes % 1024));
      for (int i = 0; i < got_a.size() && i < exp_writes; i++) begin
         chk({tag, "_wa"}, 32'(got_a[i]), 32'(i % 1024));
         chk({tag, "_wd"}, 32'(got_d[i]), 32'(words[i]));
      end
      chk({tag, "_rst_hold"}, 32'(rst_viol), 0);
   endtask

   task automatic do_reload();
      @(negedge clk);
      reload = 1'b1;
      #1 chk("reload_cpu_rst_now", 32'(cpu_rst), 1);
      @(negedge clk);
      reload = 1'b0;
      got_a.delete(); got_d.delete();
      exp_writes = 0;
      chk("reload_done",  32'(done),     0);
      chk("reload_error", 32'(error),    0);
      chk("reload_ready", 32'(in_ready), 1);
      chk("reload_addr",  32'(mem_addr), 0);
      chk("reload_cpu",   32'(cpu_rst),  1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; in_valid = 1'b0; reload = 1'b0;
      @(negedge clk);
      chk("rst_ready", 32'(in_ready), 1);
      chk("rst_wr",    32'(mem_wr),   0);
      chk("rst_addr",  32'(mem_addr), 0);
      chk("rst_data",  32'(mem_data), 0);
      chk("rst_cpu",   32'(cpu_rst),  1);
      chk("rst_done",  32'(done),     0);
      chk("rst_error", 32'(error),    0);
      rst = 1'b0;
      got_a.delete(); got_d.delete();
      exp_writes = 0;
   endtask

   initial begin
      int n;
      bit bad;
      rst = 1'b1; in_valid = 1'b0; reload = 1'b0; in_data = 8'h00;
      do_reset();

      // frame 1 with good checksum
      words = '{16'h1234, 16'hABCD};
      build(1'b0);
      send(frame.size(), 0);
      finish_check("t1", 1'b1);
      do_reload();

      // frame 1 with checksum 45
      build(1'b0);
      frame[frame.size()-1] = 8'h45;
      send(frame.size(), 0);
      finish_check("t2", 1'b0);
      do_reload();

      // empty program
      words.delete();
      build(1'b0);
      send(frame.size(), 0);
      finish_check("t3_empty", 1'b1);
      do_reload();

      // length 1025 aborts immediately after LEN_LO
      frame = '{8'h04, 8'h01, 8'h12, 8'h34};
      words.delete();
      exp_writes = 0;
      send(2, 0);
      finish_check("t3_ovf", 1'b0);
      do_reload();

      // frame 1 with in_valid toggling
      words = '{16'h1234, 16'hABCD};
      build(1'b0);
      send(frame.size(), 1);
      finish_check("t4", 1'b1);
      do_reload();

      // reset mid-frame after the high byte of word 1, then a clean load
      build(1'b0);
      send(5, 0);
      do_reset();
      build(1'b0);
      send(frame.size(), 0);
      finish_check("t5", 1'b1);

      // reload from DONE, then a one-word program
      do_reload();
      words = '{16'hFFFF};
      build(1'b0);
      send(frame.size(), 0);
      finish_check("t6", 1'b1);
      do_reload();

      // randomized frames
      for (int r = 0; r < 10; r++) begin
         n   = $urandom_range(0, 24);
         bad = ($urandom_range(0, 2) == 0);
         rand_words(n);
         build(bad);
         send(frame.size(), 2);
         finish_check("rnd", !bad);
         do_reload();
      end

      // largest legal program: address wraps back to 0 after the last write
      rand_words(1024);
      build(1'b0);
      send(frame.size(), 0);
      finish_check("max", 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
